// File: rtl/filter_sp_controller.sv
// Scratchpad fill/read sequencer: streams filter words in, replays each filter reuse times, retires it.
// Build option FILTER_SP_CIRCULAR_EN: write and base pointers wrap inside the usable region.
module filter_sp_controller #(
  parameter int SP_SIZE              = 8,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int POINTER_SIZE         = 8,
  parameter int REUSE_SIZE           = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            clear,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] num_filters,
  input  logic [REUSE_SIZE-1:0]           reuse_count,
  input  logic                            av_input,
  input  logic                            read_req,
  output logic                            write_en_src_pad,
  output logic [POINTER_SIZE-1:0]         write_addr,
  output logic [POINTER_SIZE-1:0]         read_addr,
  output logic                            av_filter,
  output logic                            end_of_pass,
  output logic                            end_of_filter,
  output logic                            done,
  output logic                            cfg_err
);
  // state | meaning
  // IDLE  | waiting for a valid start; cfg_err reports the last rejected one
  // RUN   | filling the scratchpad and streaming filter words to the consumer
  // DONE  | all filters retired; held until clear
  localparam int FW = FILTER_SIZE_REG_SIZE;
  localparam int PW = POINTER_SIZE;
  localparam int RW = REUSE_SIZE;
  localparam int TW = POINTER_SIZE + FILTER_SIZE_REG_SIZE;
  localparam logic [TW-1:0] SP_T = TW'(SP_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [FW-1:0] fs_q, nf_q, widx, fcnt;
  logic [RW-1:0] reuse_q, pass;
  logic [PW-1:0] len_q, wp, base, occ;
  logic [TW-1:0] total_q, written;
  logic          done_q, cfg_err_q;

  logic [TW-1:0] fs_in, nf_in, fs_div, total_in;
  logic [PW-1:0] len_in;
  logic          cfg_bad;

  always_comb begin
    fs_in    = TW'(filter_size);
    nf_in    = TW'(num_filters);
    fs_div   = (fs_in == '0) ? TW'(1) : fs_in;
    len_in   = PW'(SP_T - (SP_T % fs_div));
    total_in = fs_in * nf_in;
    cfg_bad  = (fs_in == '0) || (fs_in > SP_T) || (nf_in == '0);
`ifndef FILTER_SP_CIRCULAR_EN
    cfg_bad  = cfg_bad || (total_in > TW'(len_in));
`endif
  end

  logic          run, we, av, fire, last_word, last_pass, eop, eof;
  logic [PW-1:0] wp_next, base_next, rd_addr, occ_next;
`ifdef FILTER_SP_CIRCULAR_EN
  logic [PW:0]   rd_sum, base_sum;
`endif

  always_comb begin
    run       = (state == RUN);
    we        = run && av_input && (written < total_q) && (occ < len_q);
    av        = run && (TW'(widx) < TW'(occ));
    fire      = read_req && av;
    last_word = (widx == fs_q - FW'(1));
    last_pass = (pass == reuse_q - RW'(1));
    eop       = fire && last_word && !last_pass;
    eof       = fire && last_word && last_pass;
    occ_next  = occ + PW'(we) - (eof ? PW'(fs_q) : '0);
`ifdef FILTER_SP_CIRCULAR_EN
    // len_q is a multiple of fs, so base lands exactly on len_q when it wraps
    rd_sum    = {1'b0, base} + (PW + 1)'(widx);
    base_sum  = {1'b0, base} + (PW + 1)'(fs_q);
    rd_addr   = (rd_sum >= {1'b0, len_q}) ? PW'(rd_sum - {1'b0, len_q}) : PW'(rd_sum);
    wp_next   = (wp == len_q - PW'(1)) ? '0 : wp + PW'(1);
    base_next = (base_sum >= {1'b0, len_q}) ? '0 : PW'(base_sum);
`else
    rd_addr   = base + PW'(widx);
    wp_next   = wp + PW'(1);
    base_next = base + PW'(fs_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fs_q      <= '0;
      nf_q      <= '0;
      reuse_q   <= '0;
      len_q     <= '0;
      total_q   <= '0;
      written   <= '0;
      wp        <= '0;
      base      <= '0;
      occ       <= '0;
      widx      <= '0;
      pass      <= '0;
      fcnt      <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      fs_q      <= '0;
      nf_q      <= '0;
      reuse_q   <= '0;
      len_q     <= '0;
      total_q   <= '0;
      written   <= '0;
      wp        <= '0;
      base      <= '0;
      occ       <= '0;
      widx      <= '0;
      pass      <= '0;
      fcnt      <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b0;
              fs_q      <= filter_size;
              nf_q      <= num_filters;
              reuse_q   <= (reuse_count == '0) ? RW'(1) : reuse_count;
              len_q     <= len_in;
              total_q   <= total_in;
              written   <= '0;
              wp        <= '0;
              base      <= '0;
              occ       <= '0;
              widx      <= '0;
              pass      <= '0;
              fcnt      <= '0;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          occ <= occ_next;
          if (we) begin
            written <= written + TW'(1);
            wp      <= wp_next;
          end
          if (fire) begin
            if (!last_word) begin
              widx <= widx + FW'(1);
            end else if (!last_pass) begin
              widx <= '0;
              pass <= pass + RW'(1);
            end else begin
              widx <= '0;
              pass <= '0;
              base <= base_next;
              fcnt <= fcnt + FW'(1);
              if (fcnt == nf_q - FW'(1)) begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign write_en_src_pad = we;
  assign write_addr       = wp;
  assign read_addr        = rd_addr;
  assign av_filter        = av;
  assign end_of_pass      = eop;
  assign end_of_filter    = eof;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_filter_sp_controller.sv
// Scoreboard bench for filter_sp_controller: stimulus queues expected writes/reads, a monitor checks them.
module tb_filter_sp_controller;
  localparam int SP = 8;
  localparam int FW = 8;
  localparam int PW = 8;
  localparam int RW = 8;
`ifdef FILTER_SP_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [FW-1:0] filter_size = '0;
  logic [FW-1:0] num_filters = '0;
  logic [RW-1:0] reuse_count = '0;
  logic          av_input = 1'b0;
  logic          read_req = 1'b0;
  logic          write_en_src_pad;
  logic [PW-1:0] write_addr;
  logic [PW-1:0] read_addr;
  logic          av_filter;
  logic          end_of_pass;
  logic          end_of_filter;
  logic          done;
  logic          cfg_err;

  filter_sp_controller #(
    .SP_SIZE(SP), .FILTER_SIZE_REG_SIZE(FW), .POINTER_SIZE(PW), .REUSE_SIZE(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .filter_size(filter_size), .num_filters(num_filters), .reuse_count(reuse_count),
    .av_input(av_input), .read_req(read_req),
    .write_en_src_pad(write_en_src_pad), .write_addr(write_addr), .read_addr(read_addr),
    .av_filter(av_filter), .end_of_pass(end_of_pass), .end_of_filter(end_of_filter),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int addr;
    bit eop;
    bit eof;
    bit last;
    int f;
    int w;
    int gidx;
  } rd_t;

  int  wq[$];
  rd_t rq[$];

  bit m_run = 0, m_done = 0, m_cfg_err = 0;
  int m_fs = 0, m_l = 0, m_t = 0, m_written = 0, m_retired = 0, m_reads = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int usable(int fs);
    return SP - (SP % fs);
  endfunction

  function automatic bit cfg_ok(int fs, int nf);
    if (fs == 0 || fs > SP || nf == 0) return 1'b0;
    if (!CIRC && nf * fs > usable(fs)) return 1'b0;
    return 1'b1;
  endfunction

  // Word k of the job lives at k mod L; each filter is replayed reuse times in order.
  function automatic void push_job(int fs, int nf, int reuse);
    int  l  = usable(fs);
    int  re = (reuse == 0) ? 1 : reuse;
    rd_t r;
    for (int k = 0; k < nf * fs; k++) wq.push_back(k % l);
    for (int f = 0; f < nf; f++)
      for (int p = 0; p < re; p++)
        for (int w = 0; w < fs; w++) begin
          r.gidx = f * fs + w;
          r.addr = r.gidx % l;
          r.eop  = (w == fs - 1) && (p != re - 1);
          r.eof  = (w == fs - 1) && (p == re - 1);
          r.last = r.eof && (f == nf - 1);
          r.f    = f;
          r.w    = w;
          rq.push_back(r);
        end
  endfunction

  always @(negedge clk) begin : monitor
    int  occ, wbefore, wa;
    bit  exp_we, exp_av;
    rd_t r;
    if (!rst_n) begin
      chk("reset_outputs_zero", {write_en_src_pad, av_filter, end_of_pass, end_of_filter,
                                 done, cfg_err, write_addr, read_addr}, 0);
      m_run = 0; m_done = 0; m_cfg_err = 0;
      m_written = 0; m_retired = 0; m_reads = 0;
      wq.delete(); rq.delete();
    end else begin
      occ     = m_written - m_retired * m_fs;
      wbefore = m_written;
      exp_we  = m_run && av_input && (m_written < m_t) && (occ < m_l);
      exp_av  = m_run && (rq.size() != 0) && (rq[0].w < occ);
      chk("write_en", write_en_src_pad, exp_we);
      chk("av_filter", av_filter, exp_av);
      chk("done", done, m_done);
      chk("cfg_err", cfg_err, m_cfg_err);
      if (write_en_src_pad) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else begin
          wa = wq.pop_front();
          chk("write_addr", write_addr, wa);
        end
        m_written++;
      end
      if (read_req && av_filter) begin
        if (rq.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("read_addr", read_addr, r.addr);
          chk("end_of_pass", end_of_pass, r.eop);
          chk("end_of_filter", end_of_filter, r.eof);
          chk("read_after_write", r.gidx < wbefore, 1);
          m_reads++;
          if (r.eof) m_retired++;
          if (r.last) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end else begin
        chk("no_pulse_without_fire", {end_of_pass, end_of_filter}, 0);
      end
      if (clear) begin
        m_run = 0; m_done = 0; m_cfg_err = 0;
        wq.delete(); rq.delete();
      end else if (start && !m_run && !m_done) begin
        if (cfg_ok(int'(filter_size), int'(num_filters))) begin
          m_run = 1; m_cfg_err = 0;
          m_fs = int'(filter_size);
          m_l  = usable(m_fs);
          m_t  = int'(num_filters) * m_fs;
          m_written = 0; m_retired = 0; m_reads = 0;
        end else begin
          m_cfg_err = 1;
        end
      end
    end
  end

  // av_mode: 0 always, 1 random, 2 every other cycle. rr_mode: 0 always, 1 random.
  task automatic run_job(input int fs, input int nf, input int reuse,
                         input int av_mode, input int rr_mode, input int rr_hold);
    int c;
    bit ok;
    ok = cfg_ok(fs, nf);
    if (ok) push_job(fs, nf, reuse);
    filter_size = FW'(fs);
    num_filters = FW'(nf);
    reuse_count = RW'(reuse);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (ok) begin
      c = 0;
      while (!done && c < 1000) begin
        case (av_mode)
          0: av_input = 1'b1;
          1: av_input = 1'($urandom_range(0, 1));
          default: av_input = (c % 2 == 0);
        endcase
        if (c < rr_hold) read_req = 1'b0;
        else if (rr_mode == 1) read_req = 1'($urandom_range(0, 1));
        else read_req = 1'b1;
        if (av_mode == 1 && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          filter_size = FW'($urandom_range(0, 9));
        end
        @(posedge clk); #1;
        start = 1'b0;
        c++;
      end
      chk("job_done_within_budget", done, 1);
      chk("queues_drained", wq.size() + rq.size(), 0);
    end else begin
      av_input = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
    av_input = 1'b0;
    read_req = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(3, 2, 1, 0, 0, 0);
    run_job(2, 1, 2, 0, 0, 0);
    run_job(4, 1, 1, 2, 0, 0);
    run_job(0, 1, 1, 0, 0, 0);
    run_job(9, 1, 1, 0, 0, 0);
    run_job(3, 0, 1, 0, 0, 0);
    run_job(3, 3, 1, 0, 0, 0);
    run_job(3, 4, 1, 0, 0, 12);
    run_job(8, 1, 0, 1, 1, 0);
    run_job(1, 4, 3, 1, 1, 0);

    // clear has priority over a simultaneous valid start
    filter_size = 8'd3; num_filters = 8'd1; reuse_count = 8'd1;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0; av_input = 1'b1;
    @(negedge clk); #1;
    chk("clear_beats_start", write_en_src_pad, 0);
    av_input = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of a job
    push_job(3, 2, 1);
    filter_size = 8'd3; num_filters = 8'd2; reuse_count = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; av_input = 1'b1; read_req = 1'b1;
    c = 0;
    while (!(m_written >= 2 && m_reads >= 1) && c < 50) begin
      @(negedge clk); #1;
      c++;
    end
    chk("reset_window_reached", (m_written >= 2 && m_reads >= 1), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs_zero", {write_en_src_pad, av_filter, end_of_pass, end_of_filter,
                                     done, cfg_err, write_addr, read_addr}, 0);
    av_input = 1'b0; read_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(3, 2, 1, 0, 0, 0);

    for (int j = 0; j < 12; j++)
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 3)), 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_sp_controller.md
FILTER_SP_CONTROLLER -- requirements
Module: filter_sp_controller

Interface
REQ-001 The block SHALL have parameter SP_SIZE, default 8: scratchpad depth in words.
REQ-002 The block SHALL have parameter FILTER_SIZE_REG_SIZE, default 8: width of the filter_size and num_filters inputs.
REQ-003 The block SHALL have parameter POINTER_SIZE, default 8: address width, with 2^POINTER_SIZE > SP_SIZE.
REQ-004 The block SHALL have parameter REUSE_SIZE, default 8: width of reuse_count.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches configuration.
- clear  in  1  synchronous abort; returns the block to IDLE.
- filter_size  in  FILTER_SIZE_REG_SIZE  words per filter (fs).
- num_filters  in  FILTER_SIZE_REG_SIZE  filters per job (nf).
- reuse_count  in  REUSE_SIZE  read passes per filter; 0 is treated as 1.
- av_input  in  1  source word available.
- read_req  in  1  consumer ready for a word.
- write_en_src_pad  out  1  write the current source word.
- write_addr  out  POINTER_SIZE  write address.
- read_addr  out  POINTER_SIZE  read address (base+widx).
- av_filter  out  1  word at read_addr is valid.
- end_of_pass  out  1  pulse: non-final pass of a filter done.
- end_of_filter  out  1  pulse: final pass of a filter done.
- done  out  1  job complete.
- cfg_err  out  1  rejected configuration.

Function
REQ-007 The block SHALL implement states IDLE, RUN and DONE.
- IDLE->RUN on start when the configuration is valid.
- RUN->DONE when nf filters are retired.
- DONE->IDLE on clear.
- Any state->IDLE on clear; clear overrides start in the same cycle.
REQ-008 On start in IDLE, the block SHALL latch fs, nf and reuse; start outside IDLE SHALL be ignored.
REQ-009 Usable region: L = SP_SIZE - (SP_SIZE % fs); job size T = nf*fs, computed at POINTER_SIZE+FILTER_SIZE_REG_SIZE bits.
REQ-010 The block SHALL set cfg_err and remain in IDLE when fs==0, fs>SP_SIZE, or nf==0; cfg_err stays set until the next valid start or clear.
REQ-011 Write rule: write_en_src_pad = RUN && av_input && written<T && occ<L, driven combinationally from registered state.
- write_addr = wp.
- On each write, wp advances by 1.
REQ-012 Occupancy: occ counts words written but not retired; av_filter = RUN && (widx < occ).
REQ-013 Read fire = read_req && av_filter; on each fire, widx advances by 1.
- At widx==fs-1 with more passes left: widx returns to 0, pass advances, and end_of_pass is asserted.
- At widx==fs-1 on the final pass: widx and pass return to 0, base advances by fs, occ decreases by fs, and end_of_filter is asserted.
REQ-014 end_of_pass and end_of_filter SHALL be combinational single-cycle pulses in the fire cycle.
REQ-015 A write and a retire in the same cycle SHALL update occ by +1-fs.
REQ-016 On the nf-th end_of_filter, the block SHALL enter DONE at the next edge.
- done=1 while in DONE.
- No writes or reads occur in DONE.
REQ-017 read_req without av_filter SHALL stall with read_addr held; av_input while writing is not permitted SHALL be dropped, not buffered.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE and clear all counters and latched configuration.
- While rst_n is low, all outputs are 0 and read_addr/write_addr are 0.
- Reset mid-RUN abandons the job; the next start begins from address 0.
REQ-019 clear SHALL produce the same register state as reset, at the clock edge.

Configuration
REQ-020 Macro FILTER_SP_CIRCULAR_EN SHALL select the scratchpad addressing mode.
- Defined: wp and base wrap from L-1 to 0, and T>L is legal, so retired filters are refilled while later filters stream in.
- Undefined: T>L raises cfg_err; wp and base never wrap.

Verification
REQ-021 SP_SIZE=8, fs=3, nf=2, reuse=1, read_req=1, av_input=1 for 7 cycles -> write_addr 0..5; 7th word dropped; reads 0,1,2 (end_of_filter), then 3,4,5 (end_of_filter); done next cycle.
REQ-022 fs=2, nf=1, reuse=2 -> read_addr sequence 0,1,0,1; end_of_pass on the 2nd fire, end_of_filter on the 4th; done follows.
REQ-023 fs=4, nf=1, av_input every other cycle, read_req=1 -> av_filter toggles with occupancy; reads never overtake writes; 4 fires total.
REQ-024 fs=0 -> cfg_err=1, state IDLE; non-circular fs=3, nf=3 (T=9>L=6) -> cfg_err=1; circular build, same values -> RUN, no cfg_err.
REQ-025 Circular build, SP_SIZE=8, fs=3, nf=4, read_req low initially -> writes stall at occ=6; after the first end_of_filter, the next write goes to write_addr 0; all 12 words are read in order; done asserts.
REQ-026 rst_n low mid-RUN (after 2 writes and 1 read) -> all outputs 0 immediately; the next start begins at write_addr 0 and read_addr 0.
